// File: rtl/cpu_pkg.sv
// Shared opcode map, sequencer states, IR field positions and
// register decode helpers for the control sequencer.
package cpu_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  localparam int MAX_REGS = 32;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_HALT, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    C_BIN, C_UNA, C_MULDIV, C_HALT, C_ILL
  } opc_class_t;

  typedef struct packed {
    logic pc_out;
    logic zhi_out;
    logic zlo_out;
    logic mdr_out;
    logic mar_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic inc_pc;
    logic read;
    logic hi_in;
    logic lo_in;
    logic zhi_in;
    logic zlo_in;
    logic done;
  } ctl_t;

  function automatic logic reg_valid(
    input logic [3:0] idx,
    input int         nregs
  );
    return int'(idx) < nregs;
  endfunction

  // Out-of-range indices decode to all zeros so no register is touched.
  function automatic logic [MAX_REGS-1:0] reg_onehot(
    input logic [3:0] idx,
    input int         nregs
  );
    logic [MAX_REGS-1:0] oh;
    oh = '0;
    if (reg_valid(idx, nregs))
      oh = MAX_REGS'(1) << idx;
    return oh;
  endfunction

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier feeding the sequencer's
// instruction-path selection.
module opcode_class
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output opc_class_t cls
);

  always_comb begin
    cls = C_ILL;
    unique case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
        cls = C_BIN;
      OP_NEG, OP_NOT:
        cls = C_UNA;
      OP_MUL, OP_DIV:
        cls = C_MULDIV;
      OP_HALT:
        cls = C_HALT;
      default:
        cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch with bounded memory wait,
// then per-class execute steps; outputs registered from next state.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int NREGS   = 16,
  parameter int OPC_W   = 5,
  parameter int MEM_TMO = 15
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      ir,
  input  logic             mem_rdy,
  output logic             PCout,
  output logic             Zhighout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             MARin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             IncPC,
  output logic             Read,
  output logic             HIin,
  output logic             LOin,
  output logic             ZHighIn,
  output logic             ZLowIn,
  output logic [OPC_W-1:0] alu_op,
  output logic [NREGS-1:0] reg_in,
  output logic [NREGS-1:0] reg_out,
  output logic             done,
  output logic             fault
);

  localparam int CW = $clog2(MEM_TMO + 1);

  state_t           state, nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  ctl_t             ctl, ctl_nxt;
  logic [OPC_W-1:0] alu_q, alu_nxt;
  logic [NREGS-1:0] rin_q, rin_nxt;
  logic [NREGS-1:0] rout_q, rout_nxt;
  logic             fault_q;

  logic [4:0]       opc;
  logic [3:0]       ra, rb, rc;
  logic [NREGS-1:0] ra_oh, rb_oh, rc_oh;
  logic             regs_ok;
  opc_class_t       cls;
  logic             unused_ir;

  assign opc = ir[OPC_HI:OPC_LO];
  assign ra  = ir[RA_HI:RA_LO];
  assign rb  = ir[RB_HI:RB_LO];
  assign rc  = ir[RC_HI:RC_LO];
  assign unused_ir = ^ir[RC_LO-1:0];

  assign ra_oh = NREGS'(reg_onehot(ra, NREGS));
  assign rb_oh = NREGS'(reg_onehot(rb, NREGS));
  assign rc_oh = NREGS'(reg_onehot(rc, NREGS));
  assign regs_ok = reg_valid(ra, NREGS)
                && reg_valid(rb, NREGS)
                && reg_valid(rc, NREGS);

  opcode_class u_cls (
    .opcode (opc),
    .cls    (cls)
  );

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      S_IDLE: if (run) nxt = S_T0;
      S_T0:   nxt = S_T1;
      S_T1: begin
        cnt_nxt = '0;
        nxt     = mem_rdy ? S_T2 : S_T1W;
      end
      S_T1W: begin
        if (mem_rdy)
          nxt = S_T2;
        else if (cnt == CW'(MEM_TMO - 1))
          nxt = S_FAULT;
        else
          cnt_nxt = cnt + 1'b1;
      end
      S_T2: begin
        unique case (cls)
          C_HALT:  nxt = S_HALT;
          C_ILL:   nxt = S_FAULT;
          default: nxt = regs_ok ? S_T3 : S_FAULT;
        endcase
      end
      S_T3: nxt = S_T4;
      S_T4: nxt = (cls == C_UNA) ? S_IDLE : S_T5;
      S_T5: nxt = (cls == C_MULDIV) ? S_T6 : S_IDLE;
      S_T6: nxt = S_IDLE;
      S_HALT, S_FAULT: nxt = state;
      default: nxt = S_IDLE;
    endcase
  end

  // Decode the state being entered so every output is a flop.
  always_comb begin
    ctl_nxt  = '0;
    alu_nxt  = '0;
    rin_nxt  = '0;
    rout_nxt = '0;
    unique case (nxt)
      S_T0: begin
        ctl_nxt.pc_out = 1'b1;
        ctl_nxt.mar_in = 1'b1;
        ctl_nxt.inc_pc = 1'b1;
      end
      S_T1, S_T1W: begin
        ctl_nxt.read   = 1'b1;
        ctl_nxt.mdr_in = 1'b1;
      end
      S_T2: begin
        ctl_nxt.mdr_out = 1'b1;
        ctl_nxt.ir_in   = 1'b1;
      end
      S_T3: begin
        rout_nxt = rb_oh;
        if (cls == C_UNA) begin
          alu_nxt        = OPC_W'(opc);
          ctl_nxt.zlo_in = 1'b1;
        end else begin
          ctl_nxt.y_in = 1'b1;
        end
      end
      S_T4: begin
        if (cls == C_UNA) begin
          ctl_nxt.zlo_out = 1'b1;
          ctl_nxt.done    = 1'b1;
          rin_nxt         = ra_oh;
        end else begin
          rout_nxt       = rc_oh;
          alu_nxt        = OPC_W'(opc);
          ctl_nxt.zlo_in = 1'b1;
          ctl_nxt.zhi_in = (cls == C_MULDIV);
        end
      end
      S_T5: begin
        ctl_nxt.zlo_out = 1'b1;
        if (cls == C_MULDIV) begin
          ctl_nxt.lo_in = 1'b1;
        end else begin
          rin_nxt      = ra_oh;
          ctl_nxt.done = 1'b1;
        end
      end
      S_T6: begin
        ctl_nxt.zhi_out = 1'b1;
        ctl_nxt.hi_in   = 1'b1;
        ctl_nxt.done    = 1'b1;
      end
      S_HALT: ctl_nxt.done = (state != S_HALT);
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ctl     <= '0;
      alu_q   <= '0;
      rin_q   <= '0;
      rout_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_nxt;
      ctl     <= ctl_nxt;
      alu_q   <= alu_nxt;
      rin_q   <= rin_nxt;
      rout_q  <= rout_nxt;
      fault_q <= (nxt == S_FAULT);
    end
  end

  assign PCout    = ctl.pc_out;
  assign Zhighout = ctl.zhi_out;
  assign Zlowout  = ctl.zlo_out;
  assign MDRout   = ctl.mdr_out;
  assign MARin    = ctl.mar_in;
  assign PCin     = ctl.pc_in;
  assign MDRin    = ctl.mdr_in;
  assign IRin     = ctl.ir_in;
  assign Yin      = ctl.y_in;
  assign IncPC    = ctl.inc_pc;
  assign Read     = ctl.read;
  assign HIin     = ctl.hi_in;
  assign LOin     = ctl.lo_in;
  assign ZHighIn  = ctl.zhi_in;
  assign ZLowIn   = ctl.zlo_in;
  assign done     = ctl.done;
  assign alu_op   = alu_q;
  assign reg_in   = rin_q;
  assign reg_out  = rout_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle output vectors
// against hand-derived expectations, plus an NREGS=8 instance.
module tb_control_sequencer;
  import cpu_pkg::*;

  localparam int TMO = 15;

  localparam logic [15:0] M_PCOUT  = 16'h8000;
  localparam logic [15:0] M_ZHOUT  = 16'h4000;
  localparam logic [15:0] M_ZLOUT  = 16'h2000;
  localparam logic [15:0] M_MDROUT = 16'h1000;
  localparam logic [15:0] M_MARIN  = 16'h0800;
  localparam logic [15:0] M_MDRIN  = 16'h0200;
  localparam logic [15:0] M_IRIN   = 16'h0100;
  localparam logic [15:0] M_YIN    = 16'h0080;
  localparam logic [15:0] M_INCPC  = 16'h0040;
  localparam logic [15:0] M_READ   = 16'h0020;
  localparam logic [15:0] M_HIIN   = 16'h0010;
  localparam logic [15:0] M_LOIN   = 16'h0008;
  localparam logic [15:0] M_ZHIN   = 16'h0004;
  localparam logic [15:0] M_ZLIN   = 16'h0002;
  localparam logic [15:0] M_DONE   = 16'h0001;

  localparam logic [15:0] V_T0 = M_PCOUT | M_MARIN | M_INCPC;
  localparam logic [15:0] V_RD = M_READ | M_MDRIN;
  localparam logic [15:0] V_T2 = M_MDROUT | M_IRIN;

  logic        clock = 1'b0;
  logic        clear, run, mem_rdy;
  logic [31:0] ir;

  logic PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin;
  logic Yin, IncPC, Read, HIin, LOin, ZHighIn, ZLowIn, done, fault;
  logic [4:0]  alu_op;
  logic [15:0] reg_in, reg_out;
  logic [15:0] stb;

  logic PCout8, Zhighout8, Zlowout8, MDRout8, MARin8, PCin8, MDRin8;
  logic IRin8, Yin8, IncPC8, Read8, HIin8, LOin8, ZHighIn8, ZLowIn8;
  logic done8, fault8;
  logic [4:0]  alu_op8;
  logic [7:0]  reg_in8, reg_out8;
  logic [15:0] stb8;

  int n_run = 0;
  int n_fail = 0;
  int delay = 0;
  int rd_n = 0;
  int rd_tot = 0;
  int cyc = 0;
  int t0_cyc = 0;
  int rdy_cyc = 0;
  int t2_cyc = 0;
  int done_cyc = 0;

  always #5 clock = ~clock;

  control_sequencer #(.NREGS(16), .OPC_W(5), .MEM_TMO(TMO)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_rdy(mem_rdy),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .MDRout(MDRout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read), .HIin(HIin),
    .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .alu_op(alu_op),
    .reg_in(reg_in), .reg_out(reg_out), .done(done), .fault(fault)
  );

  control_sequencer #(.NREGS(8), .OPC_W(5), .MEM_TMO(TMO)) dut8 (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_rdy(mem_rdy),
    .PCout(PCout8), .Zhighout(Zhighout8), .Zlowout(Zlowout8),
    .MDRout(MDRout8), .MARin(MARin8), .PCin(PCin8), .MDRin(MDRin8),
    .IRin(IRin8), .Yin(Yin8), .IncPC(IncPC8), .Read(Read8),
    .HIin(HIin8), .LOin(LOin8), .ZHighIn(ZHighIn8), .ZLowIn(ZLowIn8),
    .alu_op(alu_op8), .reg_in(reg_in8), .reg_out(reg_out8),
    .done(done8), .fault(fault8)
  );

  assign stb = {PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin,
                IRin, Yin, IncPC, Read, HIin, LOin, ZHighIn, ZLowIn, done};
  assign stb8 = {PCout8, Zhighout8, Zlowout8, MDRout8, MARin8, PCin8,
                 MDRin8, IRin8, Yin8, IncPC8, Read8, HIin8, LOin8,
                 ZHighIn8, ZLowIn8, done8};

  function automatic logic [31:0] mk_ir(
    input logic [4:0] op,
    input logic [3:0] a, b, c
  );
    return {op, a, b, c, 15'd0};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Memory responder: mem_rdy rises on Read cycle number delay+1.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (Read) begin
      rd_n++;
      rd_tot++;
    end else begin
      rd_n = 0;
    end
    mem_rdy = Read && (rd_n > delay);
    if (PCout)   t0_cyc   = cyc;
    if (mem_rdy) rdy_cyc  = cyc;
    if (IRin)    t2_cyc   = cyc;
    if (done)    done_cyc = cyc;
  endtask

  task automatic step(
    input string       tag,
    input logic [15:0] s,
    input logic [4:0]  a,
    input logic [15:0] ri,
    input logic [15:0] ro,
    input logic        f
  );
    tick();
    chk(tag, 64'({stb, alu_op, reg_in, reg_out, fault}),
             64'({s, a, ri, ro, f}));
  endtask

  initial begin
    clear = 1'b1; run = 1'b0; ir = '0; mem_rdy = 1'b0;
    tick();
    tick();
    chk("reset", 64'({stb, alu_op, reg_in, reg_out, fault}), 64'd0);

    // NEG r4 <- -r3, memory always ready
    clear = 1'b0; ir = 32'h8A1B8000; delay = 0; run = 1'b1;
    step("neg_t0", V_T0, 5'd0, 16'h0, 16'h0, 1'b0);
    step("neg_t1", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    step("neg_t2", V_T2, 5'd0, 16'h0, 16'h0, 1'b0);
    step("neg_t3", M_ZLIN, 5'b10001, 16'h0, 16'h0008, 1'b0);
    step("neg_t4", M_ZLOUT | M_DONE, 5'd0, 16'h0010, 16'h0, 1'b0);
    step("neg_idle_gap", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);
    step("neg_refetch", V_T0, 5'd0, 16'h0, 16'h0, 1'b0);
    clear = 1'b1;
    step("clr_in_t0", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);
    clear = 1'b0;

    // ADD r5 <- r6 + r7 with three wait states
    ir = mk_ir(OP_ADD, 4'd5, 4'd6, 4'd7); delay = 3; rd_tot = 0;
    step("add_t0", V_T0, 5'd0, 16'h0, 16'h0, 1'b0);
    step("add_t1", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    step("add_w1", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    step("add_w2", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    step("add_w3", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    step("add_t2", V_T2, 5'd0, 16'h0, 16'h0, 1'b0);
    step("add_t3", M_YIN, 5'd0, 16'h0, 16'h0040, 1'b0);
    step("add_t4", M_ZLIN, OP_ADD, 16'h0, 16'h0080, 1'b0);
    step("add_t5", M_ZLOUT | M_DONE, 5'd0, 16'h0020, 16'h0, 1'b0);
    chk("add_read_len", 64'(rd_tot), 64'd4);
    chk("add_t2_after_rdy", 64'(t2_cyc - rdy_cyc), 64'd1);
    chk("add_done_incl_cycles", 64'(done_cyc - t0_cyc + 1), 64'd9);
    run = 1'b0;
    step("add_idle", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);
    step("add_idle_hold", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);

    // MUL r1:r? <- r2 * r3; run dropped after T0 must not abort
    ir = mk_ir(OP_MUL, 4'd1, 4'd2, 4'd3); delay = 0; run = 1'b1;
    step("mul_t0", V_T0, 5'd0, 16'h0, 16'h0, 1'b0);
    run = 1'b0;
    step("mul_t1", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    step("mul_t2", V_T2, 5'd0, 16'h0, 16'h0, 1'b0);
    step("mul_t3", M_YIN, 5'd0, 16'h0, 16'h0004, 1'b0);
    step("mul_t4", M_ZHIN | M_ZLIN, OP_MUL, 16'h0, 16'h0008, 1'b0);
    step("mul_t5", M_ZLOUT | M_LOIN, 5'd0, 16'h0, 16'h0, 1'b0);
    step("mul_t6", M_ZHOUT | M_HIIN | M_DONE, 5'd0, 16'h0, 16'h0, 1'b0);
    step("mul_idle", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);

    // Memory never answers: TMO+1 Read cycles then FAULT
    ir = mk_ir(OP_ADD, 4'd1, 4'd1, 4'd1); delay = 1000; run = 1'b1;
    step("tmo_t0", V_T0, 5'd0, 16'h0, 16'h0, 1'b0);
    run = 1'b0;
    for (int i = 0; i <= TMO; i++)
      step("tmo_wait", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    step("tmo_fault", 16'h0, 5'd0, 16'h0, 16'h0, 1'b1);
    run = 1'b1;
    step("tmo_fault_hold", 16'h0, 5'd0, 16'h0, 16'h0, 1'b1);
    clear = 1'b1; run = 1'b0;
    step("tmo_clear", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);
    clear = 1'b0;

    // Illegal opcode 11111
    ir = mk_ir(5'b11111, 4'd0, 4'd0, 4'd0); delay = 0; run = 1'b1;
    step("ill_t0", V_T0, 5'd0, 16'h0, 16'h0, 1'b0);
    run = 1'b0;
    step("ill_t1", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    step("ill_t2", V_T2, 5'd0, 16'h0, 16'h0, 1'b0);
    step("ill_fault", 16'h0, 5'd0, 16'h0, 16'h0, 1'b1);
    step("ill_fault_hold", 16'h0, 5'd0, 16'h0, 16'h0, 1'b1);
    clear = 1'b1;
    step("ill_clear", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);
    clear = 1'b0;

    // HALT: single done pulse, then quiet even with run high
    ir = mk_ir(OP_HALT, 4'd0, 4'd0, 4'd0); run = 1'b1;
    step("halt_t0", V_T0, 5'd0, 16'h0, 16'h0, 1'b0);
    step("halt_t1", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    step("halt_t2", V_T2, 5'd0, 16'h0, 16'h0, 1'b0);
    step("halt_entry", M_DONE, 5'd0, 16'h0, 16'h0, 1'b0);
    step("halt_hold", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);
    step("halt_hold2", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);
    clear = 1'b1;
    step("halt_clear", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);
    clear = 1'b0;

    // Clear mid-T1W must also reset the wait counter
    ir = mk_ir(OP_ADD, 4'd1, 4'd1, 4'd1); delay = 1000;
    step("cw_t0", V_T0, 5'd0, 16'h0, 16'h0, 1'b0);
    step("cw_t1", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    step("cw_w1", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    step("cw_w2", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    clear = 1'b1;
    step("cw_clear", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);
    clear = 1'b0;

    // NOT r2 <- ~r9, memory answers on the last allowed cycle
    ir = mk_ir(OP_NOT, 4'd2, 4'd9, 4'd0); delay = TMO;
    step("not_t0", V_T0, 5'd0, 16'h0, 16'h0, 1'b0);
    run = 1'b0;
    for (int i = 0; i <= TMO; i++)
      step("not_wait", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    step("not_t2", V_T2, 5'd0, 16'h0, 16'h0, 1'b0);
    step("not_t3", M_ZLIN, 5'b10010, 16'h0, 16'h0200, 1'b0);
    step("not_t4", M_ZLOUT | M_DONE, 5'd0, 16'h0004, 16'h0, 1'b0);
    step("not_idle", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);

    // SUB with Rc=9: clear in T4; NREGS=8 copy faults after T2
    clear = 1'b1;
    step("sub_preclear", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);
    clear = 1'b0;
    ir = mk_ir(OP_SUB, 4'd1, 4'd2, 4'd9); delay = 0; run = 1'b1;
    step("sub_t0", V_T0, 5'd0, 16'h0, 16'h0, 1'b0);
    run = 1'b0;
    step("sub_t1", V_RD, 5'd0, 16'h0, 16'h0, 1'b0);
    step("sub_t2", V_T2, 5'd0, 16'h0, 16'h0, 1'b0);
    chk("n8_t2", 64'({stb8, fault8}), 64'({V_T2, 1'b0}));
    step("sub_t3", M_YIN, 5'd0, 16'h0, 16'h0004, 1'b0);
    chk("n8_fault", 64'({stb8, alu_op8, reg_in8, reg_out8, fault8}),
                    64'({16'h0, 5'd0, 8'h0, 8'h0, 1'b1}));
    step("sub_t4", M_ZLIN, OP_SUB, 16'h0, 16'h0200, 1'b0);
    clear = 1'b1;
    step("sub_clear_t4", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);
    chk("n8_clear", 64'(fault8), 64'd0);
    clear = 1'b0;
    step("sub_idle", 16'h0, 5'd0, 16'h0, 16'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
